// File: rtl/ball_centroid_pkg.sv
// rtl/ball_centroid_pkg.sv - shared widths, divider timing and FSM encoding for ball_centroid
package ball_centroid_pkg;

    localparam int X_W        = 11;
    localparam int Y_W        = 10;
    localparam int SUM_W      = 32;
    localparam int CNT_W      = 20;
    localparam int DIV_CYCLES = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_CYCLES) + 1;
    localparam int CYC_W      = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_X = 2'd1,
        ST_DIV_Y = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ball_centroid_div.sv
// rtl/ball_centroid_div.sv - seq_div: restoring 32b/20b divider, one quotient bit per cycle
module seq_div
    import ball_centroid_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [SUM_W-1:0] quotient,
    output logic             done
);

    logic [CNT_W-1:0]     rem_q, rem_d, dvs_q, dvs_d;
    logic [SUM_W-1:0]     quo_q, quo_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic [CNT_W-1:0] rem_src, dvs_src, step_rem;
    logic [SUM_W-1:0] quo_src, step_quo;
    logic [CNT_W:0]   shifted;
    logic             ge;

    // The start edge already performs the first step, so 32 edges yield 32 quotient bits.
    always_comb begin
        rem_src  = start ? '0 : rem_q;
        quo_src  = start ? dividend : quo_q;
        dvs_src  = start ? divisor : dvs_q;
        shifted  = {rem_src, quo_src[SUM_W-1]};
        ge       = shifted >= {1'b0, dvs_src};
        step_rem = ge ? (shifted[CNT_W-1:0] - dvs_src) : shifted[CNT_W-1:0];
        step_quo = {quo_src[SUM_W-2:0], ge};
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = step_rem;
            quo_d = step_quo;
            dvs_d = divisor;
            cnt_d = DIV_CNT_W'(DIV_CYCLES - 1);
        end else if (cnt_q != '0) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = cnt_q - DIV_CNT_W'(1);
            done_d = (cnt_q == DIV_CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/ball_centroid.sv
// rtl/ball_centroid.sv - binary-mask centroid per frame; BALL_CENTROID_BBOX_EN adds bounding-box outputs
module ball_centroid
    import ball_centroid_pkg::*;
#(
    parameter int IMG_W   = 1280,
    parameter int IMG_H   = 720,
    parameter int MIN_PIX = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_valid,
    input  logic           pix_sof,
    input  logic           pix_bin,
    output logic [X_W-1:0] cent_x,
    output logic [Y_W-1:0] cent_y,
    output logic           cent_found,
    output logic           cent_valid,
    output logic           busy,
    output logic           overrun
`ifdef BALL_CENTROID_BBOX_EN
    ,
    output logic [X_W-1:0] bbox_xmin,
    output logic [X_W-1:0] bbox_xmax,
    output logic [Y_W-1:0] bbox_ymin,
    output logic [Y_W-1:0] bbox_ymax
`endif
);

    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

    logic             started_q, started_d, frame_end_q, frame_end_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] snap_sx_q, snap_sx_d, snap_sy_q, snap_sy_d;
    logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic             snap_pend_q, snap_pend_d, overrun_q, overrun_d;
    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [X_W-1:0]   quo_x_q, quo_x_d, cent_x_q, cent_x_d;
    logic [Y_W-1:0]   cent_y_q, cent_y_d;
    logic             cent_found_q, cent_found_d;

    logic             sof_acc, accept, clear, at_x_last, at_y_last;
    logic [X_W-1:0]   cur_x;
    logic [Y_W-1:0]   cur_y;
    logic             busy_w, take, found, cyc_last;
    logic             div_start, div_done;
    logic [SUM_W-1:0] div_dividend, div_quo;
    logic             unused_quo_hi;

`ifdef BALL_CENTROID_BBOX_EN
    logic [X_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, snap_xmin_q, snap_xmin_d, snap_xmax_q, snap_xmax_d;
    logic [Y_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d, snap_ymin_q, snap_ymin_d, snap_ymax_q, snap_ymax_d;
    logic [X_W-1:0] bbox_xmin_q, bbox_xmin_d, bbox_xmax_q, bbox_xmax_d;
    logic [Y_W-1:0] bbox_ymin_q, bbox_ymin_d, bbox_ymax_q, bbox_ymax_d;
`endif

    // Accumulation: a mid-frame pix_sof or the cycle after a frame end restarts the sums.
    always_comb begin
        sof_acc     = pix_valid & pix_sof;
        accept      = pix_valid & (pix_sof | started_q);
        cur_x       = sof_acc ? '0 : x_q;
        cur_y       = sof_acc ? '0 : y_q;
        at_x_last   = (cur_x == X_LAST);
        at_y_last   = (cur_y == Y_LAST);
        clear       = sof_acc | frame_end_q;
        started_d   = started_q | sof_acc;
        frame_end_d = accept & at_x_last & at_y_last;
        x_d         = x_q;
        y_d         = y_q;
        sum_x_d     = clear ? '0 : sum_x_q;
        sum_y_d     = clear ? '0 : sum_y_q;
        cnt_d       = clear ? '0 : cnt_q;
`ifdef BALL_CENTROID_BBOX_EN
        xmin_d      = clear ? '1 : xmin_q;
        xmax_d      = clear ? '0 : xmax_q;
        ymin_d      = clear ? '1 : ymin_q;
        ymax_d      = clear ? '0 : ymax_q;
`endif
        if (accept) begin
            if (at_x_last) begin
                x_d = '0;
                y_d = at_y_last ? '0 : cur_y + Y_W'(1);
            end else begin
                x_d = cur_x + X_W'(1);
                y_d = cur_y;
            end
            if (pix_bin) begin
                sum_x_d = sum_x_d + SUM_W'(cur_x);
                sum_y_d = sum_y_d + SUM_W'(cur_y);
                cnt_d   = cnt_d + CNT_W'(1);
`ifdef BALL_CENTROID_BBOX_EN
                if (cur_x < xmin_d) xmin_d = cur_x;
                if (cur_x > xmax_d) xmax_d = cur_x;
                if (cur_y < ymin_d) ymin_d = cur_y;
                if (cur_y > ymax_d) ymax_d = cur_y;
`endif
            end
        end
    end

    // A frame end that arrives while a division runs is dropped and flagged.
    always_comb begin
        busy_w      = (state_q == ST_DIV_X) || (state_q == ST_DIV_Y);
        take        = frame_end_q & ~busy_w & ~snap_pend_q;
        overrun_d   = frame_end_q & ~take;
        snap_pend_d = take | (snap_pend_q & (state_q != ST_IDLE));
        snap_sx_d   = take ? sum_x_q : snap_sx_q;
        snap_sy_d   = take ? sum_y_q : snap_sy_q;
        snap_cnt_d  = take ? cnt_q : snap_cnt_q;
`ifdef BALL_CENTROID_BBOX_EN
        snap_xmin_d = take ? xmin_q : snap_xmin_q;
        snap_xmax_d = take ? xmax_q : snap_xmax_q;
        snap_ymin_d = take ? ymin_q : snap_ymin_q;
        snap_ymax_d = take ? ymax_q : snap_ymax_q;
`endif
        found       = (snap_cnt_q != '0) && (snap_cnt_q >= MIN_CNT);
        cyc_last    = (cyc_q == CYC_W'(DIV_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = '0;
        case (state_q)
            ST_IDLE:  if (snap_pend_q) state_d = ST_DIV_X;
            ST_DIV_X: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_last) state_d = ST_DIV_Y;
            end
            ST_DIV_Y: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_last) state_d = ST_DONE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cent_valid = (state_q == ST_DONE);
        busy       = busy_w;
    end

    // Phases are timed by the FSM counter; a skipped divide leaves div_done low and yields 0.
    always_comb begin
        div_start    = found & (((state_q == ST_IDLE) & snap_pend_q) | ((state_q == ST_DIV_X) & cyc_last));
        div_dividend = (state_q == ST_DIV_X) ? snap_sy_q : snap_sx_q;
        quo_x_d      = quo_x_q;
        cent_x_d     = cent_x_q;
        cent_y_d     = cent_y_q;
        cent_found_d = cent_found_q;
`ifdef BALL_CENTROID_BBOX_EN
        bbox_xmin_d  = bbox_xmin_q;
        bbox_xmax_d  = bbox_xmax_q;
        bbox_ymin_d  = bbox_ymin_q;
        bbox_ymax_d  = bbox_ymax_q;
`endif
        if ((state_q == ST_DIV_X) && cyc_last) quo_x_d = div_done ? div_quo[X_W-1:0] : '0;
        if ((state_q == ST_DIV_Y) && cyc_last) begin
            cent_x_d     = quo_x_q;
            cent_y_d     = div_done ? div_quo[Y_W-1:0] : '0;
            cent_found_d = found;
`ifdef BALL_CENTROID_BBOX_EN
            bbox_xmin_d  = (snap_cnt_q != '0) ? snap_xmin_q : '0;
            bbox_xmax_d  = (snap_cnt_q != '0) ? snap_xmax_q : '0;
            bbox_ymin_d  = (snap_cnt_q != '0) ? snap_ymin_q : '0;
            bbox_ymax_d  = (snap_cnt_q != '0) ? snap_ymax_q : '0;
`endif
        end
    end

    seq_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (snap_cnt_q),
        .quotient (div_quo),
        .done     (div_done)
    );

    assign unused_quo_hi = ^div_quo[SUM_W-1:X_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q    <= 1'b0;
            frame_end_q  <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            cnt_q        <= '0;
            snap_sx_q    <= '0;
            snap_sy_q    <= '0;
            snap_cnt_q   <= '0;
            snap_pend_q  <= 1'b0;
            overrun_q    <= 1'b0;
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            quo_x_q      <= '0;
            cent_x_q     <= '0;
            cent_y_q     <= '0;
            cent_found_q <= 1'b0;
        end else begin
            started_q    <= started_d;
            frame_end_q  <= frame_end_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sum_x_q      <= sum_x_d;
            sum_y_q      <= sum_y_d;
            cnt_q        <= cnt_d;
            snap_sx_q    <= snap_sx_d;
            snap_sy_q    <= snap_sy_d;
            snap_cnt_q   <= snap_cnt_d;
            snap_pend_q  <= snap_pend_d;
            overrun_q    <= overrun_d;
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            quo_x_q      <= quo_x_d;
            cent_x_q     <= cent_x_d;
            cent_y_q     <= cent_y_d;
            cent_found_q <= cent_found_d;
        end
    end

`ifdef BALL_CENTROID_BBOX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_q      <= '1;
            xmax_q      <= '0;
            ymin_q      <= '1;
            ymax_q      <= '0;
            snap_xmin_q <= '0;
            snap_xmax_q <= '0;
            snap_ymin_q <= '0;
            snap_ymax_q <= '0;
            bbox_xmin_q <= '0;
            bbox_xmax_q <= '0;
            bbox_ymin_q <= '0;
            bbox_ymax_q <= '0;
        end else begin
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            snap_xmin_q <= snap_xmin_d;
            snap_xmax_q <= snap_xmax_d;
            snap_ymin_q <= snap_ymin_d;
            snap_ymax_q <= snap_ymax_d;
            bbox_xmin_q <= bbox_xmin_d;
            bbox_xmax_q <= bbox_xmax_d;
            bbox_ymin_q <= bbox_ymin_d;
            bbox_ymax_q <= bbox_ymax_d;
        end
    end

    assign bbox_xmin = bbox_xmin_q;
    assign bbox_xmax = bbox_xmax_q;
    assign bbox_ymin = bbox_ymin_q;
    assign bbox_ymax = bbox_ymax_q;
`endif

    assign cent_x     = cent_x_q;
    assign cent_y     = cent_y_q;
    assign cent_found = cent_found_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ball_centroid.sv
// tb/tb_ball_centroid.sv - scoreboard bench for ball_centroid on an 8x4 image
module tb_ball_centroid;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_bin = 1'b0;
    logic [10:0] cent_x;
    logic [9:0]  cent_y;
    logic        cent_found, cent_valid, busy, overrun;
`ifdef BALL_CENTROID_BBOX_EN
    logic [10:0] bbox_xmin, bbox_xmax;
    logic [9:0]  bbox_ymin, bbox_ymax;
`endif

    ball_centroid #(.IMG_W(W), .IMG_H(H), .MIN_PIX(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_bin    (pix_bin),
        .cent_x     (cent_x),
        .cent_y     (cent_y),
        .cent_found (cent_found),
        .cent_valid (cent_valid),
        .busy       (busy),
        .overrun    (overrun)
`ifdef BALL_CENTROID_BBOX_EN
        ,
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax)
`endif
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int x;
        int y;
        int found;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (overrun) ovr_seen++;
        if (cent_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_cent_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("cent_x", cent_x, e.x);
                check_eq("cent_y", cent_y, e.y);
                check_eq("cent_found", cent_found, e.found);
                check_eq("latency", cyc_cnt, e.due);
`ifdef BALL_CENTROID_BBOX_EN
                check_eq("bbox_xmin", bbox_xmin, e.xmin);
                check_eq("bbox_xmax", bbox_xmax, e.xmax);
                check_eq("bbox_ymin", bbox_ymin, e.ymin);
                check_eq("bbox_ymax", bbox_ymax, e.ymax);
`endif
            end
        end
    end

    task automatic send_frame(input logic [31:0] mask, input bit push);
        int   sx = 0, sy = 0, n = 0;
        int   xmn = W, xmx = 0, ymn = H, ymx = 0;
        exp_t e;
        for (int p = 0; p < W * H; p++) begin
            pix_valid = 1'b1;
            pix_sof   = (p == 0);
            pix_bin   = mask[p];
            if (mask[p]) begin
                sx += p % W;
                sy += p / W;
                n++;
                if (p % W < xmn) xmn = p % W;
                if (p % W > xmx) xmx = p % W;
                if (p / W < ymn) ymn = p / W;
                if (p / W > ymx) ymx = p / W;
            end
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_bin   = 1'b0;
        if (push) begin
            e.x     = (n > 0) ? sx / n : 0;
            e.y     = (n > 0) ? sy / n : 0;
            e.found = (n >= 1) ? 1 : 0;
            e.xmin  = (n > 0) ? xmn : 0;
            e.xmax  = (n > 0) ? xmx : 0;
            e.ymin  = (n > 0) ? ymn : 0;
            e.ymax  = (n > 0) ? ymx : 0;
            e.due   = cyc_cnt + 66;
            sb_q.push_back(e);
        end
    endtask

    task automatic send_loose(input int n, input bit with_sof);
        for (int p = 0; p < n; p++) begin
            pix_valid = 1'b1;
            pix_sof   = with_sof && (p == 0);
            pix_bin   = 1'b1;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_bin   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check_eq(tag, sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_cent_x"}, cent_x, 0);
        check_eq({tag, "_cent_y"}, cent_y, 0);
        check_eq({tag, "_found"}, cent_found, 0);
        check_eq({tag, "_valid"}, cent_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_overrun"}, overrun, 0);
`ifdef BALL_CENTROID_BBOX_EN
        check_eq({tag, "_bbox"}, {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 0);
`endif
    endtask

    initial begin
        logic [31:0] m;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pixels before the first pix_sof must not count.
        send_loose(5, 1'b0);
        send_frame(32'h1 << (2 * W + 3), 1'b1);
        repeat (10) @(negedge clk);
        check_eq("busy_in_div", busy, 1);
        drain("drain_single");
        repeat (5) @(negedge clk);
        check_eq("hold_x", cent_x, 3);
        check_eq("hold_y", cent_y, 2);
        check_eq("hold_found", cent_found, 1);

        send_frame(32'h0, 1'b1);
        drain("drain_zero");

        send_frame((32'h1 << 1) | (32'h1 << (3 * W + 4)), 1'b1);
        drain("drain_two");

        send_loose(10, 1'b1);
        send_frame(32'h1 << 31, 1'b1);
        drain("drain_partial");

        m = $urandom() | 32'h1;
        send_frame(m, 1'b1);
        send_frame($urandom(), 1'b0);
        ovr_exp++;
        drain("drain_b2b");
        repeat (80) @(posedge clk);
        check_eq("overrun_count", ovr_seen, ovr_exp);

        send_frame(32'h00F0_0F00, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_div_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        send_frame(32'h1 << (W + 5), 1'b1);
        drain("drain_after_reset");

        for (int i = 0; i < 4; i++) begin
            send_frame($urandom(), 1'b1);
            drain("drain_random");
        end
        check_eq("overrun_total", ovr_seen, ovr_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
